fetch_pc_unit: RTL
==================

# fetch_pc_unit

Instruction-fetch stage feeding the IF/ID pipeline register. Holds the program counter, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and presents a fetched instruction with its PC and PC+4 to the IF/ID register. Branch and jump redirects from EX have top priority: they squash any in-flight response and restart fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit hold; IF/ID is holding this cycle
- redirect  in  1  taken branch/jump from EX
- redirect_pc  in  32  target PC; bits [1:0] ignored
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (= pc_q)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid (one pulse per granted request, ≥1 cycle after gnt)
- imem_rdata  in  32  instruction word
- INST_F  out  32  instruction to IF/ID (NOP 32'h0000_0013 when not valid)
- PC_F  out  32  PC of INST_F (= pc_q)
- PC4_F  out  32  pc_q + 4, modulo 2^32
- fetch_valid  out  1  INST_F holds a real fetched instruction

## Operation
- State: pc_q[31:0] (bits [1:0] always 0), inst_q[31:0], drop_q, FSM {S_REQ, S_WAIT, S_VALID}.
- S_REQ: imem_req=1, imem_addr=pc_q. gnt -> S_WAIT. No gnt -> stay in S_REQ; address held stable.
- S_WAIT: imem_req=0. rvalid with drop_q=0 -> inst_q<=imem_rdata, go to S_VALID. rvalid with drop_q=1 -> clear drop_q, discard data, go to S_REQ.
- S_VALID: fetch_valid=1, INST_F=inst_q. stall=1 -> hold everything. stall=0 -> pc_q<=pc_q+4, go to S_REQ.
- Outside S_VALID: fetch_valid=0 and INST_F=NOP, so IF/ID captures bubbles.
- stall has no effect in S_REQ and S_WAIT: the in-flight fetch continues.
- Redirect beats stall and every FSM transition. It loads pc_q<={redirect_pc[31:2],2'b00} and clears fetch_valid next cycle. Next state:
  - S_WAIT without rvalid this cycle: set drop_q, stay in S_WAIT.
  - S_REQ with gnt this cycle: set drop_q, go to S_WAIT.
  - S_WAIT with rvalid this cycle, S_REQ without gnt, or S_VALID: drop_q=0, go to S_REQ.
- At most one outstanding request. A granted request is never abandoned: its response is always consumed, then kept or dropped.

## Timing
- Reset (rst=1 at a clk edge): pc_q=RESET_PC, state=S_REQ, drop_q=0, inst_q=NOP.
- imem_req is gated by !rst. During reset the outputs are imem_req=0, fetch_valid=0, INST_F=NOP, PC_F=RESET_PC, PC4_F=RESET_PC+4.
- First request is cycle 1 after rst deasserts.
- Zero-wait memory (gnt with req, rvalid next cycle): REQ → WAIT → VALID. fetch_valid is high 2 cycles after the request cycle, giving a throughput of 1 instruction per 3 cycles with no stall.
- Redirect asserted in cycle N: imem_req for the target is asserted in cycle N+1 if nothing is outstanding. Otherwise it is asserted the cycle after the dropped rvalid.
- All outputs are combinational from registered state only. No input-to-output paths except imem_req gating by rst.
- rst mid-transaction: state is forced immediately. A later rvalid for the old request is ignored, because S_REQ ignores rvalid.

## Structure
- riscv_pkg (shared):
  - NOP_INSTR = 32'h0000_0013
  - fetch_state_t enum {S_REQ, S_WAIT, S_VALID}
  - XLEN = 32
- Single module. No sub-module: the PC register and next-PC mux are small enough to inline.

## Test plan
- Reset with RESET_PC=32'h100 and zero-wait memory returning 32'hAAAA_0001 → imem_addr=0x100 in cycle 1; fetch_valid=1, INST_F=32'hAAAA_0001, PC_F=0x100, PC4_F=0x104 in cycle 3; next request is to 0x104.
- stall held 4 cycles in S_VALID → INST_F/PC_F stable and no imem_req. Release stall → request to PC+4 on the next cycle.
- gnt delayed 3 cycles, rvalid delayed 5 cycles → imem_addr stable throughout, exactly one capture, and fetch_valid stays 0 until capture.
- Redirect to 32'h2002 in S_WAIT before rvalid, old data 32'hDEAD_BEEF → DEAD_BEEF never appears on INST_F; the next request is to 0x2000.
- Redirect in the same cycle as rvalid, and redirect together with stall in S_VALID → both go to S_REQ at the redirect target, and fetch_valid=0 the next cycle.
- pc_q=32'hFFFF_FFFC advancing → PC4_F=0 and the next request is to 0x0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, the canonical NOP and the
// fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_VALID
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, runs one req/gnt/rvalid transaction at a
// time and presents the fetched instruction, its PC and PC+4 to IF/ID.
module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] INST_F,
    output logic [XLEN-1:0] PC_F,
    output logic [XLEN-1:0] PC4_F,
    output logic            fetch_valid
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            drop_q, drop_d;

    // Target PCs are word aligned, so the low bits of redirect_pc carry nothing.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
            inst_q  <= NOP_INSTR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
        end
    end

    // A redirect overrides everything, but a request already granted must still
    // have its response consumed, so it is marked for dropping instead.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;
        if (redirect) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            if ((state_q == S_WAIT && !imem_rvalid) || (state_q == S_REQ && imem_gnt)) begin
                state_d = S_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = S_REQ;
                drop_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_gnt) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_d  = imem_rdata;
                            state_d = S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Outputs depend only on registered state; rst merely gates the request.
    always_comb begin
        imem_req    = (state_q == S_REQ) && !rst;
        imem_addr   = pc_q;
        fetch_valid = (state_q == S_VALID);
        INST_F      = (state_q == S_VALID) ? inst_q : NOP_INSTR;
        PC_F        = pc_q;
        PC4_F       = pc_q + 32'd4;
    end

endmodule
